// File: rtl/fifo_search.sv
// Synchronous FIFO with a multi-lane masked content search over the occupied entries.
// Define FIFO_SEARCH_FWFT_EN for first-word-fall-through reads; the default is a registered read.
module fifo_search #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int LANES      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] wdat,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] rdat,
    output logic                  rvld,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  srch_req,
    input  logic [DATA_WIDTH-1:0] srch_dat,
    input  logic [DATA_WIDTH-1:0] srch_mask,
    output logic                  srch_busy,
    output logic                  srch_done,
    output logic                  srch_hit,
    output logic [ADDR_WIDTH-1:0] srch_idx,
    output logic [1:0]            srch_state
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int OW    = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
    logic                  wr_acc, rd_acc;

    logic [DATA_WIDTH-1:0] key_q, mask_q;
    logic [ADDR_WIDTH:0]   base_q;
    logic [OW-1:0]         len_q, scan_off;
    logic [LANES-1:0]      lane_hit;
    logic                  any_hit, scan_last;
    logic [ADDR_WIDTH-1:0] hit_off;

    // Handshakes: a write happens on a clock edge where wren=1 and full=0; a read happens
    // where rden=1, empty=0 and srch_busy=0. rvld marks the cycle rdat carries popped data.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                        (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign count      = wr_ptr - rd_ptr;
    assign srch_busy  = (state == S_SCAN);
    assign srch_state = state;
    assign wr_acc     = wren & ~full;
    assign rd_acc     = rden & ~empty & ~srch_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wdat;
    end

`ifdef FIFO_SEARCH_FWFT_EN
    assign rvld = ~empty & ~srch_busy;
    assign rdat = rvld ? mem[rd_ptr[ADDR_WIDTH-1:0]] : '0;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rvld <= 1'b0;
            rdat <= '0;
        end else begin
            rvld <= rd_acc;
            rdat <= rd_acc ? mem[rd_ptr[ADDR_WIDTH-1:0]] : '0;
        end
    end
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [OW-1:0]         off;
        logic [ADDR_WIDTH-1:0] slot;
        assign off         = scan_off + OW'(l);
        assign slot        = base_q[ADDR_WIDTH-1:0] + off[ADDR_WIDTH-1:0];
        assign lane_hit[l] = (off < len_q) && (((mem[slot] ^ key_q) & mask_q) == '0);
    end

    // Walk lanes high to low so the lowest matching offset is the one kept.
    always_comb begin
        any_hit = |lane_hit;
        hit_off = scan_off[ADDR_WIDTH-1:0];
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_hit[l]) hit_off = scan_off[ADDR_WIDTH-1:0] + ADDR_WIDTH'(l);
        end
    end

    assign scan_last = (scan_off + OW'(LANES)) >= len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            srch_done <= 1'b0;
            srch_hit  <= 1'b0;
            srch_idx  <= '0;
            key_q     <= '0;
            mask_q    <= '0;
            base_q    <= '0;
            len_q     <= '0;
            scan_off  <= '0;
        end else begin
            srch_done <= 1'b0;
            srch_hit  <= 1'b0;
            srch_idx  <= '0;
            case (state)
                S_IDLE, S_RESULT: begin
                    state <= S_IDLE;
                    if (srch_req) begin
                        // A read popping on this same edge is excluded from the snapshot.
                        key_q    <= srch_dat;
                        mask_q   <= srch_mask;
                        base_q   <= rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_acc};
                        len_q    <= OW'(count) - OW'(rd_acc);
                        scan_off <= '0;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    scan_off <= scan_off + OW'(LANES);
                    if (any_hit || scan_last) begin
                        state     <= S_RESULT;
                        srch_done <= 1'b1;
                        srch_hit  <= any_hit;
                        srch_idx  <= any_hit ? hit_off : '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_search.sv
// Directed bench for fifo_search (ADDR_WIDTH=4, LANES=4): drivers push expectations into
// queues and a negedge monitor pops and compares read data and search results.
`timescale 1ns/1ps
module tb_fifo_search;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int LN = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wren = 1'b0;
    logic [DW-1:0] wdat = '0;
    logic          rden = 1'b0;
    logic [DW-1:0] rdat;
    logic          rvld, full, empty;
    logic [AW:0]   count;
    logic          srch_req = 1'b0;
    logic [DW-1:0] srch_dat = '0;
    logic [DW-1:0] srch_mask = '0;
    logic          srch_busy, srch_done, srch_hit;
    logic [AW-1:0] srch_idx;
    logic [1:0]    srch_state;

    fifo_search #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(LN)) dut (
        .clk(clk), .rst(rst), .wren(wren), .wdat(wdat), .rden(rden), .rdat(rdat),
        .rvld(rvld), .full(full), .empty(empty), .count(count), .srch_req(srch_req),
        .srch_dat(srch_dat), .srch_mask(srch_mask), .srch_busy(srch_busy),
        .srch_done(srch_done), .srch_hit(srch_hit), .srch_idx(srch_idx),
        .srch_state(srch_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];        // read data in pop order
    logic [36:0]   exp_srch_q[$];   // {done cycle, hit, idx}
    logic [DW-1:0] model[$];        // FIFO contents as the bench expects them

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [36:0] e;
        if (rvld) begin
            if (exp_q.size() == 0) check("rvld_unexpected", rvld, 1'b0);
            else check("rdat", rdat, exp_q.pop_front());
        end
        if (srch_done) begin
            if (exp_srch_q.size() == 0) check("done_unexpected", srch_done, 1'b0);
            else begin
                e = exp_srch_q.pop_front();
                check("done_cycle", cyc, e[36:5]);
                check("srch_hit", srch_hit, e[4]);
                check("srch_idx", srch_idx, e[3:0]);
            end
        end else begin
            check("hit_idx_idle", {srch_hit, srch_idx}, '0);
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            wren = 1'b1;
            wdat = first + DW'(i);
            if (model.size() < 16) model.push_back(wdat);
        end
        tick();
        wren = 1'b0;
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            rden = 1'b1;
            if (model.size() > 0) exp_q.push_back(model.pop_front());
        end
        tick();
        rden = 1'b0;
    endtask

    // g = index of the group expected to end the scan; hold_rd keeps rden high through it
    task automatic search(input string name, input logic [DW-1:0] key, input logic [DW-1:0] mask,
                          input logic exp_hit, input logic [3:0] exp_idx, input int g,
                          input bit hold_rd);
        int n;
        int done_at;
        bit seen;
        tick();
        srch_req  = 1'b1;
        srch_dat  = key;
        srch_mask = mask;
        n = cyc;
        done_at = n + 2 + g;
        exp_srch_q.push_back({done_at[31:0], exp_hit, exp_idx});
        tick();
        srch_req = 1'b0;
        if (hold_rd) rden = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            check({name, "_busy"}, srch_busy, cyc < done_at);
            if (hold_rd) check({name, "_rvld_held"}, rvld, 1'b0);
            if (srch_done) seen = 1'b1;
            else tick();
        end
        if (!seen) check({name, "_timeout"}, seen, 1'b1);
        if (hold_rd && seen) begin
            if (model.size() > 0) exp_q.push_back(model.pop_front());
            tick();
            rden = 1'b0;
            @(negedge clk);
            check({name, "_rvld_resume"}, rvld, 1'b1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        repeat (3) tick();
        @(negedge clk);
        check("rst_rdat", rdat, 0);
        check("rst_rvld", rvld, 0);
        check("rst_full_empty", {full, empty}, 2'b01);
        check("rst_count", count, 0);
        check("rst_busy", srch_busy, 0);
        tick();
        rst = 1'b0;

        write_burst(32'h100, 10);
        @(negedge clk);
        check("count_10", count, 10);
        search("s105", 32'h105, 32'hFFFF_FFFF, 1'b1, 4'd5, 1, 1'b0);
        search("s200", 32'h200, 32'hFFFF_FFFF, 1'b0, 4'd0, 2, 1'b0);
        search("smask", 32'h1AB, 32'hFFFF_FF00, 1'b1, 4'd0, 0, 1'b0);

        read_n(10);
        @(negedge clk);
        check("empty_after_drain", empty, 1);
        search("sempty", 32'h100, 32'hFFFF_FFFF, 1'b0, 4'd0, 0, 1'b0);

        write_burst(32'h300, 16);
        @(negedge clk);
        check("full_16", {full, count}, {1'b1, 5'd16});
        read_n(12);
        write_burst(32'h400, 8);
        @(negedge clk);
        check("wrap_count_12", {full, count}, {1'b0, 5'd12});
        search("swrap", 32'h407, 32'hFFFF_FFFF, 1'b1, 4'd11, 2, 1'b0);
        search("sstale", 32'h309, 32'hFFFF_FFFF, 1'b0, 4'd0, 2, 1'b0);

        read_n(12);
        write_burst(32'h500, 16);
        @(negedge clk);
        check("refill_full", {full, count}, {1'b1, 5'd16});
        tick();
        wren = 1'b1;
        wdat = 32'hBAD;
        rden = 1'b1;
        exp_q.push_back(model.pop_front());
        tick();
        wren = 1'b0;
        rden = 1'b0;
        @(negedge clk);
        check("full_wr_rd", {full, count}, {1'b0, 5'd15});

        search("shold", 32'hDEAD, 32'hFFFF_FFFF, 1'b0, 4'd0, 3, 1'b1);
        @(negedge clk);
        check("count_after_hold", count, 14);
        search("slast", 32'h50F, 32'hFFFF_FFFF, 1'b1, 4'd13, 3, 1'b0);

        // reset lands mid-scan of a depth-spanning search
        tick();
        srch_req  = 1'b1;
        srch_dat  = 32'hDEAD;
        srch_mask = 32'hFFFF_FFFF;
        n = cyc;
        tick();
        srch_req = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("busy_before_rst", {srch_busy, cyc == n + 2}, 2'b11);
        tick();
        rst = 1'b0;
        model.delete();
        @(negedge clk);
        check("midrst_rdat_rvld", {rdat, rvld}, '0);
        check("midrst_flags", {full, empty, count}, {1'b0, 1'b1, 5'd0});
        check("midrst_search", {srch_busy, srch_done, srch_hit, srch_idx}, '0);
        repeat (6) tick();

        write_burst(32'h600, 3);
        read_n(3);
        @(negedge clk);
        check("empty_end", empty, 1);

        repeat (3) tick();
        check("rd_queue_drained", exp_q.size(), 0);
        check("srch_queue_drained", exp_srch_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
